// File: rtl/ysyx_pkg.sv
// Shared constants and encodings for the NPC architectural-state block.
package ysyx_pkg;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int unsigned REG_AW = 5;
  localparam logic [REG_AW-1:0] GPR_ZERO = '0;
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic {
    StRun    = 1'b0,
    StHalted = 1'b1
  } run_state_e;

endpackage

// File: rtl/gpr_array.sv
// General-purpose register file: two read ports and one debug read port,
// all combinational, plus one synchronous write port. x0 is hardwired to zero.
module gpr_array
  import ysyx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NREG       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [REG_AW-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [REG_AW-1:0]     raddr1,
  input  logic [REG_AW-1:0]     raddr2,
  input  logic [REG_AW-1:0]     dbg_addr,
  output logic [DATA_WIDTH-1:0] rout1,
  output logic [DATA_WIDTH-1:0] rout2,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  logic [DATA_WIDTH-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wen && (waddr != GPR_ZERO)) begin
      regs[waddr] <= wdata;
    end
  end

  // No write bypass: wdata is derived from rout1 in the same cycle.
  always_comb begin
    rout1    = (raddr1 == GPR_ZERO) ? '0 : regs[raddr1];
    rout2    = (raddr2 == GPR_ZERO) ? '0 : regs[raddr2];
    dbg_data = (dbg_addr == GPR_ZERO) ? '0 : regs[dbg_addr];
  end

endmodule

// File: rtl/gpr_pc_state.sv
// Architectural state of the single-cycle core: GPRs, PC, retired-instruction
// counter and the RUN/HALTED run-state seen by the simulation environment.
module gpr_pc_state #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           NREG       = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = ysyx_pkg::RESET_PC,
  parameter int unsigned           CNT_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step_en,
  input  logic [4:0]            raddr1,
  input  logic [4:0]            raddr2,
  output logic [DATA_WIDTH-1:0] rout1,
  output logic [DATA_WIDTH-1:0] rout2,
  input  logic [4:0]            waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] dnpc,
  input  logic                  ebreak,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] snpc,
  input  logic [4:0]            dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data,
  output logic [CNT_WIDTH-1:0]  instret,
  output logic                  halted,
  output logic                  misalign
);
  import ysyx_pkg::*;

  run_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [CNT_WIDTH-1:0]  instret_q;
  logic                  misalign_q;
  logic                  commit;
  logic                  aligned;

  assign commit  = (state_q == StRun) && step_en;
  assign aligned = (dnpc[1:0] & ALIGN_MASK) == 2'b00;

  gpr_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .NREG      (NREG)
  ) u_gpr_array (
    .clk     (clk),
    .rst     (rst),
    .wen     (commit && wen && aligned),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr1  (raddr1),
    .raddr2  (raddr2),
    .dbg_addr(dbg_addr),
    .rout1   (rout1),
    .rout2   (rout2),
    .dbg_data(dbg_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (commit && (ebreak || !aligned)) begin
      state_d = StHalted;
    end
  end

  // A misaligned commit still retires so the difftest sees the faulting instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      instret_q  <= '0;
      misalign_q <= 1'b0;
    end else if (commit) begin
      instret_q <= instret_q + CNT_WIDTH'(1);
      if (aligned) begin
        pc_q <= dnpc;
      end else begin
        misalign_q <= 1'b1;
      end
    end
  end

  always_comb begin
    halted   = (state_q == StHalted);
    pc       = pc_q;
    snpc     = pc_q + DATA_WIDTH'(4);
    instret  = instret_q;
    misalign = misalign_q;
  end

endmodule

// File: tb/tb_gpr_pc_state.sv
// Directed bench for gpr_pc_state with a behavioural architectural-state model
// checked every cycle, plus hand-computed literal expectations.
module tb_gpr_pc_state;

  logic        clk = 1'b0;
  logic        rst;
  logic        step_en;
  logic [4:0]  raddr1, raddr2, waddr, dbg_addr;
  logic [31:0] rout1, rout2, wdata, dnpc, pc, snpc, dbg_data;
  logic        wen, ebreak, halted, misalign;
  logic [63:0] instret;

  int checks = 0;
  int errors = 0;

  // Behavioural model
  logic [31:0] m_gpr [32];
  logic [31:0] m_pc;
  logic [63:0] m_instret;
  logic        m_halted, m_misalign, m_valid = 1'b0;

  always #5 clk = ~clk;

  gpr_pc_state dut (
    .clk     (clk),
    .rst     (rst),
    .step_en (step_en),
    .raddr1  (raddr1),
    .raddr2  (raddr2),
    .rout1   (rout1),
    .rout2   (rout2),
    .waddr   (waddr),
    .wdata   (wdata),
    .wen     (wen),
    .dnpc    (dnpc),
    .ebreak  (ebreak),
    .pc      (pc),
    .snpc    (snpc),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data),
    .instret (instret),
    .halted  (halted),
    .misalign(misalign)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : m_gpr[a];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
      m_pc = 32'h8000_0000;
      m_instret = 64'd0;
      m_halted = 1'b0;
      m_misalign = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid && !m_halted && step_en) begin
      m_instret = m_instret + 64'd1;
      if (dnpc % 4 != 0) begin
        m_misalign = 1'b1;
        m_halted = 1'b1;
      end else begin
        if (wen && waddr != 5'd0) m_gpr[waddr] = wdata;
        m_pc = dnpc;
        if (ebreak) m_halted = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_pc", {32'd0, pc}, {32'd0, m_pc});
      chk("m_snpc", {32'd0, snpc}, {32'd0, m_pc + 32'd4});
      chk("m_instret", instret, m_instret);
      chk("m_halted", {63'd0, halted}, {63'd0, m_halted});
      chk("m_misalign", {63'd0, misalign}, {63'd0, m_misalign});
      chk("m_rout1", {32'd0, rout1}, {32'd0, m_read(raddr1)});
      chk("m_rout2", {32'd0, rout2}, {32'd0, m_read(raddr2)});
      chk("m_dbg", {32'd0, dbg_data}, {32'd0, m_read(dbg_addr)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_commit(input logic s, input logic w, input logic [4:0] wa,
                            input logic [31:0] wd, input logic [31:0] np, input logic eb);
    step_en = s; wen = w; waddr = wa; wdata = wd; dnpc = np; ebreak = eb;
  endtask

  initial begin
    rst = 1'b1; step_en = 1'b0; wen = 1'b0; ebreak = 1'b0;
    raddr1 = '0; raddr2 = '0; waddr = '0; dbg_addr = '0; wdata = '0; dnpc = '0;
    tick();
    do_reset();

    // 1: reset state
    chk("rst_pc", {32'd0, pc}, 64'h8000_0000);
    chk("rst_snpc", {32'd0, snpc}, 64'h8000_0004);
    chk("rst_instret", instret, 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    chk("rst_misalign", {63'd0, misalign}, 64'd0);
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(31 - i); dbg_addr = 5'(i);
      #1;
      chk("rst_rout1", {32'd0, rout1}, 64'd0);
      chk("rst_rout2", {32'd0, rout2}, 64'd0);
      chk("rst_dbg", {32'd0, dbg_data}, 64'd0);
    end

    // 2: first commit, no bypass
    raddr1 = 5'd5;
    set_commit(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 32'h8000_0004, 1'b0);
    #1;
    chk("nobypass_rout1", {32'd0, rout1}, 64'd0);
    tick();
    chk("t2_rout1", {32'd0, rout1}, 64'hDEAD_BEEF);
    chk("t2_pc", {32'd0, pc}, 64'h8000_0004);
    chk("t2_instret", instret, 64'd1);

    // 3: write to x0 discarded
    dbg_addr = 5'd0;
    set_commit(1'b1, 1'b1, 5'd0, 32'h1234, 32'h8000_0008, 1'b0);
    tick();
    chk("t3_dbg_x0", {32'd0, dbg_data}, 64'd0);
    chk("t3_pc", {32'd0, pc}, 64'h8000_0008);
    chk("t3_instret", instret, 64'd2);

    // 4: step_en low holds everything
    raddr2 = 5'd7;
    set_commit(1'b0, 1'b1, 5'd7, 32'h5555_5555, 32'h8000_0100, 1'b0);
    repeat (3) tick();
    chk("t4_rout2", {32'd0, rout2}, 64'd0);
    chk("t4_pc", {32'd0, pc}, 64'h8000_0008);
    chk("t4_instret", instret, 64'd2);

    // Several commits filling registers 3,6,...,24
    for (int i = 1; i <= 8; i++) begin
      set_commit(1'b1, 1'b1, 5'(i * 3), 32'hA000_0000 + 32'(i), 32'h8000_0008 + 32'(4 * i), 1'b0);
      tick();
    end
    dbg_addr = 5'd12;
    #1;
    chk("fill_dbg12", {32'd0, dbg_data}, 64'hA000_0004);
    chk("fill_pc", {32'd0, pc}, 64'h8000_0028);
    chk("fill_instret", instret, 64'd10);

    // 5: misaligned dnpc
    raddr1 = 5'd1;
    set_commit(1'b1, 1'b1, 5'd1, 32'h0000_0ABC, 32'h8000_0102, 1'b0);
    tick();
    chk("t5_pc_held", {32'd0, pc}, 64'h8000_0028);
    chk("t5_misalign", {63'd0, misalign}, 64'd1);
    chk("t5_halted", {63'd0, halted}, 64'd1);
    chk("t5_instret", instret, 64'd11);
    chk("t5_nowrite", {32'd0, rout1}, 64'd0);
    raddr2 = 5'd2;
    set_commit(1'b1, 1'b1, 5'd2, 32'h0000_0777, 32'h8000_0100, 1'b1);
    tick();
    chk("t5_frozen_pc", {32'd0, pc}, 64'h8000_0028);
    chk("t5_frozen_instret", instret, 64'd11);
    chk("t5_frozen_gpr", {32'd0, rout2}, 64'd0);
    dbg_addr = 5'd24;
    #1;
    chk("t5_dbg_live", {32'd0, dbg_data}, 64'hA000_0008);
    do_reset();
    chk("t5_rst_misalign", {63'd0, misalign}, 64'd0);
    chk("t5_rst_halted", {63'd0, halted}, 64'd0);
    chk("t5_rst_pc", {32'd0, pc}, 64'h8000_0000);
    chk("t5_rst_gpr", {32'd0, dbg_data}, 64'd0);

    // 6: ebreak commit
    raddr1 = 5'd10;
    set_commit(1'b1, 1'b1, 5'd10, 32'h0000_0077, 32'h8000_0004, 1'b0);
    tick();
    chk("t6_pre", {32'd0, rout1}, 64'h77);
    set_commit(1'b1, 1'b1, 5'd10, 32'h0, 32'h8000_0010, 1'b1);
    tick();
    chk("t6_gpr10", {32'd0, rout1}, 64'd0);
    chk("t6_pc", {32'd0, pc}, 64'h8000_0010);
    chk("t6_halted", {63'd0, halted}, 64'd1);
    chk("t6_misalign", {63'd0, misalign}, 64'd0);
    set_commit(1'b1, 1'b1, 5'd10, 32'h99, 32'h8000_0020, 1'b0);
    repeat (2) tick();
    chk("t6_frozen_pc", {32'd0, pc}, 64'h8000_0010);
    chk("t6_frozen_instret", instret, 64'd2);

    // ebreak together with misaligned dnpc
    do_reset();
    set_commit(1'b1, 1'b1, 5'd10, 32'h1, 32'h8000_0003, 1'b1);
    tick();
    chk("ebmis_pc", {32'd0, pc}, 64'h8000_0000);
    chk("ebmis_misalign", {63'd0, misalign}, 64'd1);
    chk("ebmis_halted", {63'd0, halted}, 64'd1);
    chk("ebmis_instret", instret, 64'd1);
    chk("ebmis_nowrite", {32'd0, rout1}, 64'd0);

    set_commit(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
